// File: rtl/trig_pkg.sv
// Shared constants for the sin/cos ROM arbiter slice.
// Defaults match the 512-entry, 12-bit ROMs.
package trig_pkg;

  localparam int ADDR_W   = 9;
  localparam int DATA_W   = 12;
  localparam int NREQ_MAX = 4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W_MAX = idx_w(NREQ_MAX);

endpackage

// File: rtl/trig_rom_arbiter_rr_pick.sv
// Combinational round-robin search: first set req bit
// at or after ptr, wrapping; reusable by other arbiters.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Outer loop walks distance from ptr so the nearest wins
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!any && req[j] &&
            (((int'(ptr) + k) % N) == j)) begin
          gnt[j] = 1'b1;
          idx    = IW'(j);
          any    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/trig_rom_arbiter.sv
// Round-robin share of one sin/cos ROM pair, 2-edge latency.
// Optional per-requester grant stats: TRIG_ARB_STATS_EN.
module trig_rom_arbiter #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = trig_pkg::ADDR_W,
  parameter int DATA_W = trig_pkg::DATA_W
) (
  input  logic                   clk_pix,
  input  logic                   resetn,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_sin,
  output logic [DATA_W-1:0]      rsp_cos,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [DATA_W-1:0]      rom_sin,
  input  logic [DATA_W-1:0]      rom_cos,
  input  logic                   frame_start
`ifdef TRIG_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]     grant_count
`endif
);

  import trig_pkg::*;

  localparam int IW = idx_w(NREQ);

  logic [NREQ-1:0]   gnt;
  logic [IW-1:0]     gnt_idx;
  logic              gnt_any;

  logic [IW-1:0]     ptr_q, ptr_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              s1_valid_q, s1_valid_d;
  logic [IW-1:0]     s1_id_q, s1_id_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_sin_q, rsp_sin_d;
  logic [DATA_W-1:0] rsp_cos_q, rsp_cos_d;

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign req_ready = gnt;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sin   = rsp_sin_q;
  assign rsp_cos   = rsp_cos_q;
  assign rom_addr  = rom_addr_q;

  // Next state: pointer, ROM address stage, response stage
  always_comb begin
    ptr_d       = ptr_q;
    rom_addr_d  = rom_addr_q;
    s1_valid_d  = gnt_any;
    s1_id_d     = s1_id_q;
    rsp_valid_d = '0;
    rsp_sin_d   = rsp_sin_q;
    rsp_cos_d   = rsp_cos_q;
    if (gnt_any) begin
      ptr_d      = (gnt_idx == IW'(NREQ - 1)) ?
                   '0 : gnt_idx + 1'b1;
      rom_addr_d = req_addr[gnt_idx*ADDR_W +: ADDR_W];
      s1_id_d    = gnt_idx;
    end
    if (s1_valid_q) begin
      rsp_valid_d = NREQ'(1) << s1_id_q;
      rsp_sin_d   = rom_sin;
      rsp_cos_d   = rom_cos;
    end
  end

  // Pipeline registers; reset drops anything in flight
  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      ptr_q       <= '0;
      rom_addr_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      rsp_valid_q <= '0;
      rsp_sin_q   <= '0;
      rsp_cos_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rom_addr_q  <= rom_addr_d;
      s1_valid_q  <= s1_valid_d;
      s1_id_q     <= s1_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sin_q   <= rsp_sin_d;
      rsp_cos_q   <= rsp_cos_d;
    end
  end

`ifdef TRIG_ARB_STATS_EN
  logic [NREQ-1:0][15:0] cnt_q, cnt_d;
  logic [NREQ*16-1:0]    gcnt_q, gcnt_d;

  // Saturating grant counters, snapshotted on frame_start
  always_comb begin
    cnt_d  = cnt_q;
    gcnt_d = gcnt_q;
    for (int i = 0; i < NREQ; i++) begin
      if (frame_start) begin
        gcnt_d[i*16 +: 16] = cnt_q[i];
        cnt_d[i] = gnt[i] ? 16'd1 : 16'd0;
      end else if (gnt[i] && cnt_q[i] != 16'hFFFF) begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  // Stats registers
  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      gcnt_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      gcnt_q <= gcnt_d;
    end
  end

  assign grant_count = gcnt_q;
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
`endif

endmodule
